// File: rtl/power_06f6_driver.sv
// power_06f6_driver
// Sweeps the four stimulus lines of the power_06f6 sub-circuit through all
// 16 input vectors, in binary or Gray order, for PASSES full sweeps. Each
// vector is held for SETTLE cycles and then one SAMPLE cycle, in which n_8
// is compared against the golden function g = n_2 & (n_3 ^ n_4 ^ ~n_1).
// The block accumulates saturating mismatch, ones and toggle counts, and it
// records the first mismatching vector of the run.
module power_06f6_driver #(
    parameter int PASSES = 1,   // full 16-vector sweeps per run, 1..255
    parameter int SETTLE = 1    // hold cycles before n_8 is sampled, 1..15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       mode,
    output logic       n_1,
    output logic       n_2,
    output logic       n_3,
    output logic       n_4,
    input  logic       n_8,
    output logic       busy,
    output logic       done,
    output logic [7:0] err_cnt,
    output logic [7:0] ones_cnt,
    output logic [7:0] tog_cnt,
    output logic [3:0] first_err_vec,
    output logic       first_err_vld
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    state_t      state_reg;
    logic [3:0]  idx_reg;        // position within the current sweep
    logic [7:0]  pass_reg;       // completed sweeps in this run
    logic [3:0]  settle_reg;     // cycles already spent in SETTLE
    logic        mode_reg;       // vector order captured at start
    logic        prev_n8_reg;    // previous sample of n_8 in this run
    logic        prev_vld_reg;   // prev_n8_reg holds a real sample

    logic [3:0]  vec_cur;
    logic        golden;
    logic        mismatch;
    logic        last_vec;
    logic        last_pass;
    logic        settle_end;

    // Map a sweep position to the vector that is driven, {n_1,n_2,n_3,n_4}.
    function automatic logic [3:0] vec_of(input logic [3:0] i, input logic m);
        return m ? (i ^ (i >> 1)) : i;
    endfunction

    // Counters stop at 255 instead of wrapping.
    function automatic logic [7:0] sat_inc(input logic [7:0] c);
        return (c == 8'hFF) ? c : c + 8'd1;
    endfunction

    // The comparison uses the registered stimulus, which is what the
    // sub-circuit actually sees during SAMPLE.
    assign vec_cur    = {n_1, n_2, n_3, n_4};
    assign golden     = n_2 & (n_3 ^ n_4 ^ ~n_1);
    assign mismatch   = (n_8 != golden);
    assign last_vec   = (idx_reg == 4'd15);
    assign last_pass  = (pass_reg == 8'(PASSES - 1));
    assign settle_end = (settle_reg == 4'(SETTLE - 1));

    // Sequence controller: all state and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            idx_reg       <= 4'd0;
            pass_reg      <= 8'd0;
            settle_reg    <= 4'd0;
            mode_reg      <= 1'b0;
            prev_n8_reg   <= 1'b0;
            prev_vld_reg  <= 1'b0;
            {n_1, n_2, n_3, n_4} <= 4'd0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err_cnt       <= 8'd0;
            ones_cnt      <= 8'd0;
            tog_cnt       <= 8'd0;
            first_err_vec <= 4'd0;
            first_err_vld <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    done <= 1'b0;
                    {n_1, n_2, n_3, n_4} <= 4'd0;
                    if (start) begin
                        idx_reg       <= 4'd0;
                        pass_reg      <= 8'd0;
                        settle_reg    <= 4'd0;
                        mode_reg      <= mode;
                        prev_n8_reg   <= 1'b0;
                        prev_vld_reg  <= 1'b0;
                        err_cnt       <= 8'd0;
                        ones_cnt      <= 8'd0;
                        tog_cnt       <= 8'd0;
                        first_err_vec <= 4'd0;
                        first_err_vld <= 1'b0;
                        busy          <= 1'b1;
                        {n_1, n_2, n_3, n_4} <= vec_of(4'd0, mode);
                        state_reg     <= ST_SETTLE;
                    end
                end

                ST_SETTLE: begin
                    if (settle_end) begin
                        state_reg <= ST_SAMPLE;
                    end else begin
                        settle_reg <= settle_reg + 4'd1;
                    end
                end

                ST_SAMPLE: begin
                    if (mismatch) begin
                        err_cnt <= sat_inc(err_cnt);
                        if (!first_err_vld) begin
                            first_err_vec <= vec_cur;
                            first_err_vld <= 1'b1;
                        end
                    end
                    if (n_8) begin
                        ones_cnt <= sat_inc(ones_cnt);
                    end
                    if (prev_vld_reg && (n_8 != prev_n8_reg)) begin
                        tog_cnt <= sat_inc(tog_cnt);
                    end
                    prev_n8_reg  <= n_8;
                    prev_vld_reg <= 1'b1;
                    settle_reg   <= 4'd0;

                    if (last_vec && last_pass) begin
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        {n_1, n_2, n_3, n_4} <= 4'd0;
                        state_reg <= ST_DONE;
                    end else if (last_vec) begin
                        idx_reg   <= 4'd0;
                        pass_reg  <= pass_reg + 8'd1;
                        {n_1, n_2, n_3, n_4} <= vec_of(4'd0, mode_reg);
                        state_reg <= ST_SETTLE;
                    end else begin
                        idx_reg   <= idx_reg + 4'd1;
                        {n_1, n_2, n_3, n_4} <= vec_of(idx_reg + 4'd1, mode_reg);
                        state_reg <= ST_SETTLE;
                    end
                end

                ST_DONE: begin
                    // start is deliberately ignored here; a new run can
                    // begin only once the FSM is back in IDLE.
                    done      <= 1'b0;
                    state_reg <= ST_IDLE;
                end

                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_power_06f6_driver.sv
// Bench for power_06f6_driver: three instances with different PASSES/SETTLE
// share start/mode/rst. Each one has a responder that models the
// sub-circuit, either correctly or stuck at 0 or 1. A per-instance
// reference model predicts busy/done/stimulus every cycle and the final
// counts of each run.
module tb_power_06f6_driver;

    localparam int NI = 3;
    localparam int PS[NI] = '{1, 2, 1};
    localparam int SS[NI] = '{1, 1, 3};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic mode = 1'b0;
    int   tie = 0;          // 0: correct sub-circuit, 1: n_8 stuck 0, 2: stuck 1
    bit   checking = 1'b0;
    int   checks = 0;
    int   errors = 0;

    typedef struct packed {
        logic [7:0] e;
        logic [7:0] o;
        logic [7:0] t;
        logic [3:0] fv;
        logic       fvld;
    } res_t;

    always #5 clk = ~clk;

    // Golden response for v = {n_1,n_2,n_3,n_4}.
    function automatic logic gold(input logic [3:0] v);
        return v[2] & (v[1] ^ v[0] ^ ~v[3]);
    endfunction

    function automatic logic [3:0] vec_at(input int i, input logic m);
        logic [3:0] b;
        b = 4'(i % 16);
        return m ? (b ^ (b >> 1)) : b;
    endfunction

    function automatic logic resp(input logic [3:0] v, input int t);
        if (t == 1) return 1'b0;
        if (t == 2) return 1'b1;
        return gold(v);
    endfunction

    // Whole-run result predicted by walking every sample of the run.
    function automatic res_t model_run(input int p, input logic m, input int t);
        res_t r;
        int e, o, tg;
        logic prev, x;
        logic [3:0] v;
        r = '0; e = 0; o = 0; tg = 0; prev = 1'b0;
        for (int s = 0; s < p * 16; s++) begin
            v = vec_at(s, m);
            x = resp(v, t);
            if (x != gold(v)) begin
                if (e == 0) begin
                    r.fv = v;
                    r.fvld = 1'b1;
                end
                e++;
            end
            if (x) o++;
            if (s > 0 && x != prev) tg++;
            prev = x;
        end
        r.e = 8'((e > 255) ? 255 : e);
        r.o = 8'((o > 255) ? 255 : o);
        r.t = 8'((tg > 255) ? 255 : tg);
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    generate
        for (genvar gi = 0; gi < NI; gi++) begin : g_inst
            localparam int P = PS[gi];
            localparam int S = SS[gi];
            localparam int L = P * 16 * (S + 1);

            logic       n_1, n_2, n_3, n_4, n_8;
            logic       busy, done, fvld;
            logic [7:0] err, ones, tog;
            logic [3:0] fev;

            logic       m_run;
            int         m_k;
            logic       m_mode;
            res_t       m_res;

            assign n_8 = resp({n_1, n_2, n_3, n_4}, tie);

            power_06f6_driver #(.PASSES(P), .SETTLE(S)) dut (
                .clk(clk), .rst(rst), .start(start), .mode(mode),
                .n_1(n_1), .n_2(n_2), .n_3(n_3), .n_4(n_4), .n_8(n_8),
                .busy(busy), .done(done),
                .err_cnt(err), .ones_cnt(ones), .tog_cnt(tog),
                .first_err_vec(fev), .first_err_vld(fvld)
            );

            // Reference timeline: m_k is the 1-based cycle number since start acceptance.
            always @(posedge clk or posedge rst) begin
                if (rst) begin
                    m_run  <= 1'b0;
                    m_k    <= 0;
                    m_mode <= 1'b0;
                    m_res  <= '0;
                end else if (!m_run) begin
                    if (start) begin
                        m_run  <= 1'b1;
                        m_k    <= 1;
                        m_mode <= mode;
                        m_res  <= model_run(P, mode, tie);
                    end
                end else if (m_k == L + 1) begin
                    m_run <= 1'b0;
                end else begin
                    m_k <= m_k + 1;
                end
            end

            // Compare process: every cycle, away from the active edge.
            always @(negedge clk) begin
                if (checking) begin
                    if (m_run && m_k <= L) begin
                        chk($sformatf("u%0d busy", gi), busy, 1);
                        chk($sformatf("u%0d done", gi), done, 0);
                        chk($sformatf("u%0d vec k=%0d", gi, m_k), {n_1, n_2, n_3, n_4},
                            vec_at((m_k - 1) / (S + 1), m_mode));
                    end else begin
                        chk($sformatf("u%0d busy", gi), busy, 0);
                        chk($sformatf("u%0d done", gi), done, (m_run ? 1 : 0));
                        chk($sformatf("u%0d vec", gi), {n_1, n_2, n_3, n_4}, 0);
                        chk($sformatf("u%0d err_cnt", gi), err, m_res.e);
                        chk($sformatf("u%0d ones_cnt", gi), ones, m_res.o);
                        chk($sformatf("u%0d tog_cnt", gi), tog, m_res.t);
                        chk($sformatf("u%0d first_err_vld", gi), fvld, m_res.fvld);
                        if (m_res.fvld)
                            chk($sformatf("u%0d first_err_vec", gi), fev, m_res.fv);
                    end
                end
            end
        end
    endgenerate

    // Wait until every instance has finished its run. Count busy cycles for
    // u0/u1 and done pulses for u0 along the way.
    task automatic wait_all(output int b0, output int b1, output int d0);
        b0 = 0; b1 = 0; d0 = 0;
        for (int n = 0; n < 4000; n++) begin
            if (!g_inst[0].m_run && !g_inst[1].m_run && !g_inst[2].m_run) break;
            if (g_inst[0].busy) b0++;
            if (g_inst[1].busy) b1++;
            if (g_inst[0].done) d0++;
            @(negedge clk);
        end
        chk("all runs complete",
            (!g_inst[0].m_run && !g_inst[1].m_run && !g_inst[2].m_run) ? 1 : 0, 1);
    endtask

    task automatic run_wait(input logic m, input int t, output int b0, output int b1, output int d0);
        mode = m;
        tie = t;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_all(b0, b1, d0);
        $display("run mode=%0d tie=%0d: u0 err=%0d ones=%0d tog=%0d vld=%0d vec=%b busy=%0d | u1 ones=%0d tog=%0d busy=%0d",
                 m, t, g_inst[0].err, g_inst[0].ones, g_inst[0].tog, g_inst[0].fvld,
                 g_inst[0].fev, b0, g_inst[1].ones, g_inst[1].tog, b1);
    endtask

    initial begin
        int b0, b1, d0, n;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checking = 1'b1;
        @(negedge clk);
        chk("reset busy", g_inst[0].busy, 0);
        chk("reset err_cnt", g_inst[0].err, 0);

        // Correct sub-circuit, binary order.
        run_wait(1'b0, 0, b0, b1, d0);
        chk("u0 busy cycles", b0, 32);
        chk("u0 done pulses", d0, 1);
        chk("u0 err_cnt lit", g_inst[0].err, 0);
        chk("u0 ones_cnt lit", g_inst[0].ones, 4);
        chk("u0 tog_cnt lit", g_inst[0].tog, 6);
        chk("u0 first_err_vld lit", g_inst[0].fvld, 0);
        chk("u1 busy cycles", b1, 64);
        chk("u1 ones_cnt lit", g_inst[1].ones, 8);
        chk("u1 tog_cnt lit", g_inst[1].tog, 12);
        chk("u1 err_cnt lit", g_inst[1].err, 0);

        // n_8 stuck at 0, binary order.
        run_wait(1'b0, 1, b0, b1, d0);
        chk("stuck0 err_cnt lit", g_inst[0].err, 4);
        chk("stuck0 first_err_vec lit", g_inst[0].fev, 4'b0100);
        chk("stuck0 first_err_vld lit", g_inst[0].fvld, 1);

        // n_8 stuck at 1, Gray order.
        run_wait(1'b1, 2, b0, b1, d0);
        chk("stuck1 err_cnt lit", g_inst[0].err, 12);
        chk("stuck1 ones_cnt lit", g_inst[0].ones, 16);
        chk("stuck1 tog_cnt lit", g_inst[0].tog, 0);
        chk("stuck1 first_err_vec lit", g_inst[0].fev, 4'b0000);

        // Correct sub-circuit, Gray order.
        run_wait(1'b1, 0, b0, b1, d0);
        chk("gray ones_cnt lit", g_inst[0].ones, 4);

        // Reset in the middle of a run, at vector 7.
        mode = 1'b0;
        tie = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while ({g_inst[0].n_1, g_inst[0].n_2, g_inst[0].n_3, g_inst[0].n_4} != 4'd7 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("reached vector 7", {g_inst[0].n_1, g_inst[0].n_2, g_inst[0].n_3, g_inst[0].n_4}, 7);
        #2 rst = 1'b1;
        #1;
        chk("async rst busy", g_inst[0].busy, 0);
        chk("async rst vec", {g_inst[0].n_1, g_inst[0].n_2, g_inst[0].n_3, g_inst[0].n_4}, 0);
        chk("async rst ones_cnt", g_inst[0].ones, 0);
        chk("async rst tog_cnt", g_inst[0].tog, 0);
        chk("async rst u1 busy", g_inst[1].busy, 0);
        $display("mid-run reset applied at vector 7");
        @(negedge clk);
        rst = 1'b0;
        start = 1'b1;       // accepted on the first rising edge after release
        @(negedge clk);
        start = 1'b0;
        chk("start right after reset", g_inst[0].busy, 1);
        wait_all(b0, b1, d0);
        chk("post-reset busy cycles", b0, 32);
        chk("post-reset err_cnt", g_inst[0].err, 0);
        chk("post-reset ones_cnt", g_inst[0].ones, 4);
        chk("post-reset tog_cnt", g_inst[0].tog, 6);
        chk("post-reset first_err_vld", g_inst[0].fvld, 0);
        $display("post-reset run: u0 err=%0d ones=%0d tog=%0d", g_inst[0].err, g_inst[0].ones, g_inst[0].tog);

        // start held high through a run and into DONE.
        start = 1'b1;
        n = 0;
        while (!g_inst[0].done && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("held start: done seen", g_inst[0].done, 1);
        @(negedge clk);
        chk("held start: idle after done", g_inst[0].busy, 0);
        @(negedge clk);
        start = 1'b0;
        chk("held start: second run from idle", g_inst[0].busy, 1);
        wait_all(b0, b1, d0);
        chk("held start: second run done pulses", d0, 1);
        $display("held-start sequence: second run done pulses=%0d", d0);

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
